// File: rtl/fdiv_s.sv
// rtl/fdiv_s.sv - iterative IEEE-754 single-precision divider (out = rs1 / rs2); `define FDIV_FLAGS_EN adds fflags
module fdiv_s #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        valid,
  output logic [31:0] out
`ifdef FDIV_FLAGS_EN
  ,
  output logic [4:0]  fflags
`endif
);

  localparam int         ITERS    = 27 / BITS_PER_CYCLE;
  localparam logic [4:0] CNT_INIT = 5'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;

  state_t      state;
  logic        sign_r;
  logic [9:0]  exp_r;
  logic [23:0] mb;
  logic [24:0] rem;
  logic [26:0] q;
  logic [4:0]  cnt;

  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn, nan_case;

  assign a_exp    = rs1[30:23];
  assign b_exp    = rs2[30:23];
  assign a_frac   = rs1[22:0];
  assign b_frac   = rs2[22:0];
  // subnormals have a zero exponent field and are treated as zero
  assign a_zero   = (a_exp == 8'h00);
  assign b_zero   = (b_exp == 8'h00);
  assign a_inf    = (a_exp == 8'hFF) && (a_frac == 23'd0);
  assign b_inf    = (b_exp == 8'hFF) && (b_frac == 23'd0);
  assign a_nan    = (a_exp == 8'hFF) && (a_frac != 23'd0);
  assign b_nan    = (b_exp == 8'hFF) && (b_frac != 23'd0);
  assign sgn      = rs1[31] ^ rs2[31];
  assign nan_case = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);

  logic        spec_hit;
  logic [31:0] spec_out;

  // special operands resolve in one cycle; first matching rule wins
  always_comb begin
    spec_hit = 1'b1;
    spec_out = 32'h0;
    if (nan_case)              spec_out = 32'h7FC00000;
    else if (a_inf)            spec_out = {sgn, 8'hFF, 23'd0};
    else if (b_zero)           spec_out = {sgn, 8'hFF, 23'd0};
    else if (a_zero || b_inf)  spec_out = {sgn, 31'd0};
    else                       spec_hit = 1'b0;
  end

  logic [24:0] rem_n;
  logic [26:0] q_n;
  logic [25:0] trial;

  // BITS_PER_CYCLE restoring steps; remainder stays below 2*mb so 25 bits suffice
  always_comb begin
    rem_n = rem;
    q_n   = q;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      trial = {1'b0, rem_n} - {2'b00, mb};
      if (!trial[25]) rem_n = trial[24:0];
      q_n   = {q_n[25:0], ~trial[25]};
      rem_n = {rem_n[23:0], 1'b0};
    end
  end

  logic [26:0] qn;
  logic [9:0]  en, ef;
  logic [23:0] mant;
  logic        g, r, s, rup, ovf, unf;
  logic [24:0] mr;
  logic [31:0] rnd_out;

  // normalise, round to nearest even, then clamp exponent to inf / flushed zero
  always_comb begin
    qn      = q[26] ? q : {q[25:0], 1'b0};
    en      = q[26] ? exp_r : exp_r - 10'd1;
    mant    = qn[26:3];
    g       = qn[2];
    r       = qn[1];
    s       = qn[0] | (rem != 25'd0);
    rup     = g & (r | s | mant[0]);
    mr      = {1'b0, mant} + {24'd0, rup};
    ef      = mr[24] ? en + 10'd1 : en;
    ovf     = ($signed(ef) >= 10'sd255);
    unf     = ($signed(ef) <= 10'sd0);
    rnd_out = ovf ? {sign_r, 8'hFF, 23'd0} :
              unf ? {sign_r, 31'd0} :
                    {sign_r, ef[7:0], mr[22:0]};
  end

`ifdef FDIV_FLAGS_EN
  logic [4:0] spec_fl, rnd_fl;
  logic       a_qnan, b_qnan;

  assign a_qnan = a_nan & a_frac[22];
  assign b_qnan = b_nan & b_frac[22];

  // exception flags {NV, DZ, OF, UF, NX} for both result paths
  always_comb begin
    spec_fl = 5'd0;
    if (nan_case)               spec_fl[4] = ~(a_qnan | b_qnan);
    else if (!a_inf && b_zero)  spec_fl[3] = 1'b1;
    rnd_fl = {2'b00, ovf, unf, g | r | s | ovf | unf};
  end
`endif

  // control FSM with datapath registers and registered result
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      busy   <= 1'b0;
      valid  <= 1'b0;
      out    <= 32'd0;
      sign_r <= 1'b0;
      exp_r  <= 10'd0;
      mb     <= 24'd0;
      rem    <= 25'd0;
      q      <= 27'd0;
      cnt    <= 5'd0;
`ifdef FDIV_FLAGS_EN
      fflags <= 5'd0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (spec_hit) begin
              out   <= spec_out;
              valid <= 1'b1;
`ifdef FDIV_FLAGS_EN
              fflags <= spec_fl;
`endif
            end else begin
              state  <= DIV;
              busy   <= 1'b1;
              sign_r <= sgn;
              exp_r  <= {2'b00, a_exp} - {2'b00, b_exp} + 10'd127;
              mb     <= {1'b1, b_frac};
              rem    <= {2'b01, a_frac};
              q      <= 27'd0;
              cnt    <= CNT_INIT;
            end
          end
        end
        DIV: begin
          rem <= rem_n;
          q   <= q_n;
          if (cnt == 5'd0) state <= ROUND;
          else             cnt   <= cnt - 5'd1;
        end
        ROUND: begin
          out   <= rnd_out;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef FDIV_FLAGS_EN
          fflags <= rnd_fl;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_s.sv
// tb/tb_fdiv_s.sv - self-checking bench for fdiv_s against an exact-quotient reference model
module tb_fdiv_s;

  localparam int BPC = 1;
  localparam int LAT = 27 / BPC + 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] rs1, rs2;
  logic        busy, valid;
  logic [31:0] out;
`ifdef FDIV_FLAGS_EN
  logic [4:0]  fflags;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sp_tab [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                              32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h3F800000};

  fdiv_s #(.BITS_PER_CYCLE(BPC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .valid  (valid),
`ifdef FDIV_FLAGS_EN
    .fflags (fflags),
`endif
    .out    (out)
  );

  always #5 clk = ~clk;

  // returns {is_special, flags[4:0], result[31:0]} from exact integer division
  function automatic logic [37:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic s, an, bn, ai, bi, az, bz, aq, bq, nv, nx;
    int ea, eb, e, sh;
    logic [22:0] fa, fb;
    longint ma, mb, num, mant, rm;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    an = (ea == 255) && (fa != 0);
    bn = (eb == 255) && (fb != 0);
    ai = (ea == 255) && (fa == 0);
    bi = (eb == 255) && (fb == 0);
    az = (ea == 0);
    bz = (eb == 0);
    aq = an && fa[22];
    bq = bn && fb[22];
    nv = !(aq || bq);
    if (an || bn || (az && bz) || (ai && bi)) return {1'b1, nv, 4'b0000, 32'h7FC00000};
    if (ai) return {1'b1, 5'b00000, s, 31'h7F800000};
    if (bz) return {1'b1, 5'b01000, s, 31'h7F800000};
    if (az || bi) return {1'b1, 5'b00000, s, 31'h0};
    ma = longint'(fa) + (longint'(1) << 23);
    mb = longint'(fb) + (longint'(1) << 23);
    e  = ea - eb + 127;
    sh = 23;
    if (ma < mb) begin
      sh = 24;
      e  = e - 1;
    end
    num  = ma << sh;
    mant = num / mb;
    rm   = num % mb;
    nx   = (rm != 0);
    if ((2 * rm > mb) || ((2 * rm == mb) && (mant % 2 == 1))) mant = mant + 1;
    if (mant == (longint'(1) << 24)) begin
      mant = longint'(1) << 23;
      e    = e + 1;
    end
    if (e >= 255) return {1'b0, 5'b00101, s, 31'h7F800000};
    if (e <= 0)   return {1'b0, 5'b00011, s, 31'h0};
    return {1'b0, 4'b0000, nx, s, e[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    if ($urandom_range(0, 7) == 0) return sp_tab[$urandom_range(0, 7)];
    return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  // called one time unit after a rising edge; returns one time unit after the edge that accepted start
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    rs1   = a;
    rs2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    rs1   = $urandom;
    rs2   = $urandom;
  endtask

  // k = rising edges after the current point until valid is seen; bc = cycles with busy high before that
  task automatic wait_valid(output int k, output int bc);
    k  = 0;
    bc = 0;
    while (valid !== 1'b1 && k < 200) begin
      if (busy === 1'b1) bc++;
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] got, output int k, output int bc);
    issue(a, b);
    wait_valid(k, bc);
    got = out;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++;
    if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++;
    if (out !== 32'h0) begin n_bad++; $display("FAIL reset_out: got %h want 00000000", out); end
`ifdef FDIV_FLAGS_EN
    n_cmp++;
    if (fflags !== 5'h0) begin n_bad++; $display("FAIL reset_fflags: got %h want 00", fflags); end
`endif
  endtask

  task automatic test_directed();
    logic [31:0] da [6] = '{32'h40C00000, 32'h3F800000, 32'hC1000000, 32'h7F7FFFFF, 32'h3F800000, 32'h00000000};
    logic [31:0] db [6] = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h3F000000, 32'h00000000, 32'h00000000};
    logic [31:0] dq [6] = '{32'h40400000, 32'h3EAAAAAB, 32'hC1800000, 32'h7F800000, 32'h7F800000, 32'h7FC00000};
    int          dl [6] = '{LAT, LAT, LAT, LAT, 0, 0};
    logic [4:0]  df [6] = '{5'h00, 5'h01, 5'h00, 5'h05, 5'h08, 5'h10};
    logic [31:0] got;
    int k, bc;
    for (int i = 0; i < 6; i++) begin
      run_op(da[i], db[i], got, k, bc);
      n_cmp++;
      if (got !== dq[i]) begin n_bad++; $display("FAIL dir%0d_out: got %h want %h", i, got, dq[i]); end
      n_cmp++;
      if (k != dl[i]) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, k, dl[i]); end
      n_cmp++;
      if (bc != dl[i]) begin n_bad++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, dl[i]); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy_at_valid: got %b want 0", i, busy); end
`ifdef FDIV_FLAGS_EN
      n_cmp++;
      if (fflags !== df[i]) begin n_bad++; $display("FAIL dir%0d_fflags: got %h want %h", i, fflags, df[i]); end
`endif
      @(posedge clk);
      #1;
      n_cmp++;
      if (valid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_valid_pulse: got %b want 0", i, valid); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, got;
    logic [37:0] r;
    int k, bc, el;
    for (int i = 0; i < 60; i++) begin
      a  = rand_operand();
      b  = rand_operand();
      r  = ref_div(a, b);
      el = r[37] ? 0 : LAT;
      run_op(a, b, got, k, bc);
      n_cmp++;
      if (got !== r[31:0]) begin n_bad++; $display("FAIL rnd%0d_out %h/%h: got %h want %h", i, a, b, got, r[31:0]); end
      n_cmp++;
      if (k != el) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, k, el); end
`ifdef FDIV_FLAGS_EN
      n_cmp++;
      if (fflags !== r[36:32]) begin n_bad++; $display("FAIL rnd%0d_fflags %h/%h: got %h want %h", i, a, b, fflags, r[36:32]); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int k, bc, stray;
    issue(32'h40C00000, 32'h40000000);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    issue(32'h3F800000, 32'h40400000);
    wait_valid(k, bc);
    n_cmp++;
    if (out !== 32'h40400000) begin n_bad++; $display("FAIL b2b_first_out: got %h want 40400000", out); end
    n_cmp++;
    if (k + 5 != LAT) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want %0d", k + 5, LAT); end
    run_op(32'hC1000000, 32'h3F000000, got, k, bc);
    n_cmp++;
    if (got !== 32'hC1800000) begin n_bad++; $display("FAIL b2b_second_out: got %h want C1800000", got); end
    n_cmp++;
    if (k != LAT) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want %0d", k, LAT); end
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid !== 1'b0) stray++;
    end
    n_cmp++;
    if (stray != 0) begin n_bad++; $display("FAIL b2b_stray_valid: got %0d pulses want 0", stray); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    int k, bc, stray;
    issue(32'h40C00000, 32'h40000000);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++;
    if (valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", valid); end
    n_cmp++;
    if (out !== 32'h0) begin n_bad++; $display("FAIL midrst_out: got %h want 00000000", out); end
    @(negedge clk);
    resetn = 1'b1;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid !== 1'b0) stray++;
    end
    n_cmp++;
    if (stray != 0) begin n_bad++; $display("FAIL midrst_stray_valid: got %0d pulses want 0", stray); end
    run_op(32'h3F800000, 32'h40400000, got, k, bc);
    n_cmp++;
    if (got !== 32'h3EAAAAAB) begin n_bad++; $display("FAIL midrst_next_out: got %h want 3EAAAAAB", got); end
    n_cmp++;
    if (k != LAT) begin n_bad++; $display("FAIL midrst_next_latency: got %0d want %0d", k, LAT); end
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    rs1    = 32'h0;
    rs2    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    resetn = 1'b1;
    @(posedge clk);
    #1;
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
